pc_fetch_sequencer: RTL and testbench



---
 rtl/pc_seq_pkg.sv | 7 +
 rtl/next_pc_sel.sv | 38 +++
 rtl/pc_fetch_sequencer.sv | 91 +++++++++
 tb/tb_pc_fetch_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: fetch-state encoding and PC constants shared by the fetch sequencer and its next-PC mux
package pc_seq_pkg;
    typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} fetch_state_t;
    localparam logic [31:0] PC_INCR       = 32'd4;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0004;
endpackage

// File: rtl/next_pc_sel.sv
// next_pc_sel: priority mux for the next PC (trap > redirect > sequential > hold)
//   pc_q/seq_adv           current PC, advance by PC_INCR when a fetch retires
//   trap_valid             selects TRAP_VEC
//   redirect_valid/target  branch/jump target
//   next_pc                selected PC
//   flow_change            trap or redirect this cycle (kills in-flight/held fetch)
//   misalign               misaligned redirect converted to a trap
//   MISALIGN_TRAP_EN       trap on misaligned targets instead of clearing bits [1:0]
module next_pc_sel
    import pc_seq_pkg::*;
#(
    parameter int              ILEN     = 32,
    parameter logic [ILEN-1:0] TRAP_VEC = ILEN'(TRAP_VEC_DEF)
) (
    input  logic [ILEN-1:0] pc_q,
    input  logic            seq_adv,
    input  logic            trap_valid,
    input  logic            redirect_valid,
    input  logic [ILEN-1:0] redirect_target,
    output logic [ILEN-1:0] next_pc,
    output logic            flow_change,
    output logic            misalign
);
    logic [ILEN-1:0] tgt;
    always_comb begin
`ifdef MISALIGN_TRAP_EN
        misalign = !trap_valid && redirect_valid && (redirect_target[1:0] != 2'b00);
        tgt = misalign ? TRAP_VEC : redirect_target;
`else
        misalign = 1'b0;
        tgt = redirect_target & ~ILEN'(3);
`endif
        flow_change = trap_valid || redirect_valid;
        next_pc = trap_valid ? TRAP_VEC :
                  redirect_valid ? tgt :
                  seq_adv ? pc_q + ILEN'(PC_INCR) : pc_q;
    end
endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the PC, fetches over a req/ack imem port and hands words to decode via valid/ready
//   clk, rst                        clock, synchronous active-high reset
//   imem_req/addr, imem_ack/rdata   fetch request (addr = pc_q) and one-cycle ack with data
//   instr_valid/ready, instr/pc     held instruction and its PC to decode
//   redirect_valid/target, trap_valid  control-flow changes (trap has priority)
//   misalign_trap                   pulse on a misaligned redirect (MISALIGN_TRAP_EN only)
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              ILEN      = 32,
    parameter logic [ILEN-1:0] RESET_VEC = ILEN'(RESET_VEC_DEF),
    parameter logic [ILEN-1:0] TRAP_VEC  = ILEN'(TRAP_VEC_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [ILEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr,
    output logic [ILEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [ILEN-1:0] redirect_target,
    input  logic            trap_valid,
    output logic            misalign_trap
);
    fetch_state_t    state_q, state_d;
    logic [ILEN-1:0] pc_q, pc_d, instr_q, instr_d, instr_pc_q, instr_pc_d;
    logic            squash_q, squash_d, misalign_q, misalign_d;
    logic            fetching, ack, keep, flow_change, misalign;

    next_pc_sel #(.ILEN(ILEN), .TRAP_VEC(TRAP_VEC)) u_next_pc (
        .pc_q           (pc_q),
        .seq_adv        (keep),
        .trap_valid     (trap_valid),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .next_pc        (pc_d),
        .flow_change    (flow_change),
        .misalign       (misalign)
    );

    always_comb begin
        fetching = state_q == REQ || state_q == WAIT;
        ack = fetching && imem_ack;
        // a word is kept only if neither an earlier nor a same-cycle redirect invalidated it
        keep = ack && !squash_q && !flow_change;
        state_d = state_q;
        squash_d = squash_q;
        instr_d = keep ? imem_rdata : instr_q;
        instr_pc_d = keep ? pc_q : instr_pc_q;
        misalign_d = misalign;
        case (state_q)
            BOOT: state_d = REQ;
            REQ, WAIT: begin
                state_d = ack ? (keep ? HOLD : REQ) : (flow_change ? state_q : WAIT);
                // a redirect while memory is busy leaves a stale ack in flight to drop
                squash_d = !ack && (squash_q || (flow_change && state_q == WAIT));
            end
            HOLD: state_d = (flow_change || instr_ready) ? REQ : HOLD;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q <= RESET_VEC;
            squash_q <= 1'b0;
            instr_q <= '0;
            instr_pc_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            squash_q <= squash_d;
            instr_q <= instr_d;
            instr_pc_q <= instr_pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req = fetching;
    assign imem_addr = pc_q;
    assign instr_valid = state_q == HOLD;
    assign instr = instr_q;
    assign instr_pc = instr_pc_q;
    assign misalign_trap = misalign_q;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed scoreboard bench; memory returns ~addr unless poisoned
module tb_pc_fetch_sequencer;
    logic        clk = 1'b0, rst = 1'b1;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        instr_valid, instr_ready = 1'b0;
    logic [31:0] instr, instr_pc;
    logic        redirect_valid = 1'b0, trap_valid = 1'b0, misalign_trap;
    logic [31:0] redirect_target = '0;

    int total = 0, bad = 0;
    int ack_delay = 0, cnt = 0;
    logic poison = 1'b0;
    logic [31:0] cap = '0;
    logic [31:0] exp_addr[$];
    logic [63:0] exp_ins[$];
    logic req_prev = 1'b0, ack_prev = 1'b0;

    always #5 clk = ~clk;

    pc_fetch_sequencer dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .misalign_trap(misalign_trap)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (instr_valid !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        if (cyc >= 100) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic consume();
        int c;
        wait_valid(c);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_instr_pc"}, instr_pc, 32'd0);
        chk({tag, "_misalign"}, 32'(misalign_trap), 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'd0);
    endtask

    initial begin
        forever begin
            step();
            imem_ack = 1'b0;
            if (imem_req === 1'b1) begin
                if (cnt == 0) cap = imem_addr;
                if (cnt == ack_delay) begin
                    imem_ack = 1'b1;
                    imem_rdata = poison ? 32'hDEAD_BEEF : ~cap;
                    poison = 1'b0;
                    cnt = 0;
                end else cnt++;
            end else cnt = 0;
        end
    end

    always @(negedge clk) begin
        logic [63:0] e;
        if (rst) begin
            req_prev = 1'b0;
            ack_prev = 1'b0;
        end else begin
            if (instr_valid === 1'b1) chk("no_poison_word", 32'(instr == 32'hDEAD_BEEF), 32'd0);
            if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
                if (exp_ins.size() == 0) chk("ins_extra", 32'd1, 32'd0);
                else begin
                    e = exp_ins.pop_front();
                    chk("ins_pc", instr_pc, e[63:32]);
                    chk("ins_word", instr, e[31:0]);
                end
            end
            if (imem_req === 1'b1 && (!req_prev || ack_prev)) begin
                if (exp_addr.size() == 0) chk("addr_extra", imem_addr, 32'hFFFF_FFFF);
                else chk("fetch_addr", imem_addr, exp_addr.pop_front());
            end
            req_prev = imem_req;
            ack_prev = imem_ack;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int c;
        logic        mis_exp;
        logic [31:0] f_addr, f_ins, n_addr;
`ifdef MISALIGN_TRAP_EN
        mis_exp = 1'b1; f_addr = 32'h4; f_ins = 32'hFFFF_FFFB; n_addr = 32'h8;
`else
        mis_exp = 1'b0; f_addr = 32'h100; f_ins = 32'hFFFF_FEFF; n_addr = 32'h104;
`endif
        step();
        step();
        reset_checks("rst");
        exp_addr.push_back(32'h0); exp_addr.push_back(32'h4);
        exp_addr.push_back(32'h8); exp_addr.push_back(32'hC);
        exp_ins.push_back({32'h0, 32'hFFFF_FFFF});
        exp_ins.push_back({32'h4, 32'hFFFF_FFFB});
        exp_ins.push_back({32'h8, 32'hFFFF_FFF7});
        rst = 1'b0;
        step();
        chk("boot_valid", 32'(instr_valid), 32'd0);
        step();
        chk("first_valid", 32'(instr_valid), 32'd1);
        repeat (3) consume();
        wait_valid(c);
        ack_delay = 3;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_instr", instr, 32'hFFFF_FFF3);
            chk("hold_pc", instr_pc, 32'hC);
            chk("hold_no_req", 32'(imem_req), 32'd0);
        end
        exp_ins.push_back({32'hC, 32'hFFFF_FFF3});
        exp_addr.push_back(32'h10);
        consume();
        wait_valid(c);
        chk("latency3", 32'(c), 32'd4);
        exp_ins.push_back({32'h10, 32'hFFFF_FFEF});
        exp_addr.push_back(32'h14);
        exp_addr.push_back(32'h100);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        poison = 1'b1;
        step();
        redirect_valid = 1'b1;
        redirect_target = 32'h100;
        step();
        redirect_valid = 1'b0;
        wait_valid(c);
        chk("squash_pc", instr_pc, 32'h100);
        chk("squash_word", instr, 32'hFFFF_FEFF);
        ack_delay = 1;
        exp_ins.push_back({32'h100, 32'hFFFF_FEFF});
        exp_addr.push_back(32'h4);
        trap_valid = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h200;
        instr_ready = 1'b1;
        step();
        trap_valid = 1'b0;
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        chk("trap_priority", imem_addr, 32'h4);
        wait_valid(c);
        exp_ins.push_back({32'h4, 32'hFFFF_FFFB});
        exp_addr.push_back(32'hFFFF_FFFC);
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        instr_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        wait_valid(c);
        exp_ins.push_back({32'hFFFF_FFFC, 32'h0000_0003});
        exp_addr.push_back(32'h0);
        consume();
        wait_valid(c);
        chk("wrap_pc", instr_pc, 32'h0);
        exp_ins.push_back({32'h0, 32'hFFFF_FFFF});
        exp_addr.push_back(f_addr);
        redirect_valid = 1'b1;
        redirect_target = 32'h102;
        instr_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        chk("mis_pulse", 32'(misalign_trap), 32'(mis_exp));
        chk("mis_addr", imem_addr, f_addr);
        step();
        chk("mis_clear", 32'(misalign_trap), 32'd0);
        exp_ins.push_back({f_addr, f_ins});
        exp_addr.push_back(n_addr);
        consume();
        step();
        rst = 1'b1;
        step();
        reset_checks("midrst");
        exp_addr.push_back(32'h0);
        rst = 1'b0;
        wait_valid(c);
        chk("post_rst_pc", instr_pc, 32'h0);
        chk("post_rst_word", instr, 32'hFFFF_FFFF);
        repeat (3) step();
        chk("ins_left", 32'(exp_ins.size()), 32'd0);
        chk("addr_left", 32'(exp_addr.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
